// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared core definitions for the pipeline hazard sequencer.
package pipe_hazard_ctrl_pkg;

  localparam int DIV_LATENCY_DEF = 32;

  typedef logic [4:0] reg_num_t;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_DIV = 1'b1
  } hz_state_e;

  // Bundle of every pipeline-register control the sequencer drives
  typedef struct packed {
    logic stall_pc;
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic bubble_ex;
    logic bubble_mem;
    logic bubble_wb;
    logic flush_all;
    logic div_done;
  } hz_ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard detect: ID source matches the destination of a load in EX.
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic     id_rs_en,
  input  logic     id_rt_en,
  input  reg_num_t id_rs_addr,
  input  reg_num_t id_rt_addr,
  input  logic     ex_load,
  input  reg_num_t ex_wr_addr,
  output logic     lu_haz
);

  logic rs_hit, rt_hit;

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  always_comb begin
    rs_hit = id_rs_en && (id_rs_addr == ex_wr_addr);
    rt_hit = id_rt_en && (id_rt_addr == ex_wr_addr);
    lu_haz = ex_load && (ex_wr_addr != 5'd0) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble/flush sequencer for the five-stage core: load-use, divider
// occupancy of EX, data-memory wait states and exception flush.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = DIV_LATENCY_DEF,
  parameter int CNT_W       = $clog2(DIV_LATENCY)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_rs_en,
  input  logic       id_rt_en,
  input  logic [4:0] id_rs_addr,
  input  logic [4:0] id_rt_addr,
  input  logic       ex_load,
  input  logic [4:0] ex_wr_addr,
  input  logic       ex_div_start,
  input  logic       dmem_req,
  input  logic       dmem_ack,
  input  logic       exc_flush,
  output logic       stall_pc,
  output logic       stall_if_id,
  output logic       stall_id_ex,
  output logic       stall_ex_mem,
  output logic       bubble_ex,
  output logic       bubble_mem,
  output logic       bubble_wb,
  output logic       flush_all,
  output logic       div_busy,
  output logic       div_done
);

  // Cycles spent in DIV with stalls asserted after the start cycle; the
  // counter reaching zero marks the cycle the quotient becomes valid.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_wait, lu_haz, div_stall;
  hz_ctrl_t         ctrl;

  assign mem_wait = dmem_req & ~dmem_ack;

  pipe_hazard_ctrl_hazard_detect u_hazard_detect (
    .id_rs_en   (id_rs_en),
    .id_rt_en   (id_rt_en),
    .id_rs_addr (id_rs_addr),
    .id_rt_addr (id_rt_addr),
    .ex_load    (ex_load),
    .ex_wr_addr (ex_wr_addr),
    .lu_haz     (lu_haz)
  );

  // State and divider countdown register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: divider countdown is free-running, only done waits on memory
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (ex_div_start && !exc_flush) begin
          state_d = ST_DIV;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_DIV: begin
        if (exc_flush) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          // start still high here is the same div leaving EX, not a new one
          if (cnt_q == '0 && !mem_wait) state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Mealy outputs; exception flush overrides every stall, bubble and done
  always_comb begin
    ctrl      = '0;
    div_stall = ((state_q == ST_RUN) && ex_div_start) ||
                ((state_q == ST_DIV) && ((cnt_q != '0) || mem_wait));
    if (exc_flush) begin
      ctrl.flush_all = 1'b1;
    end else begin
      ctrl.stall_pc     = mem_wait | div_stall | lu_haz;
      ctrl.stall_if_id  = mem_wait | div_stall | lu_haz;
      ctrl.stall_id_ex  = mem_wait | div_stall;
      ctrl.stall_ex_mem = mem_wait;
      ctrl.bubble_ex    = lu_haz & ~mem_wait & ~div_stall;
      ctrl.bubble_mem   = div_stall & ~mem_wait;
      ctrl.bubble_wb    = mem_wait;
      ctrl.div_done     = (state_q == ST_DIV) && (cnt_q == '0) && !mem_wait;
    end
  end

  assign stall_pc     = ctrl.stall_pc;
  assign stall_if_id  = ctrl.stall_if_id;
  assign stall_id_ex  = ctrl.stall_id_ex;
  assign stall_ex_mem = ctrl.stall_ex_mem;
  assign bubble_ex    = ctrl.bubble_ex;
  assign bubble_mem   = ctrl.bubble_mem;
  assign bubble_wb    = ctrl.bubble_wb;
  assign flush_all    = ctrl.flush_all;
  assign div_done     = ctrl.div_done;
  assign div_busy     = (state_q == ST_DIV);

endmodule
